sccb_config: RTL and testbench
==============================

# sccb_config

Camera configuration sequencer for the OV7670 front end. After reset, and on request, it walks a fixed table of register/value pairs and writes each one to the camera over SCCB using 3-phase write transactions (device ID, sub-address, data). It owns the `sio_c`/`sio_d` pins, which the camera controller currently parks idle, and reports `busy`/`done`/`nack` to the rest of the design.

## Interface
- `CLK_DIV`, 63: `clk_25` cycles per SCCB quarter-bit (bit = 4*CLK_DIV cycles, ≈99 kHz at default); legal 1..255
- `DEV_ID`, 8'h42: SCCB write ID byte
- `RESET_WAIT`, 25000: `clk_25` cycles idle after the soft-reset entry (1 ms)
- `clk_25`  input  1  system clock
- `reset_n`  input  1  reset; one clock; reset is asynchronous and active-low
- `start`  input  1  1-cycle pulse: rerun table; honoured only when not busy
- `sio_c`  output  1  SCCB clock, driven push-pull
- `sio_d`  inout  1  SCCB data, open-drain style: drives 0 or releases to `1'bz`
- `busy`  output  1  table walk in progress
- `done`  output  1  high after table completes, until next run/reset
- `nack`  output  1  sticky: some write saw a high ack bit (macro-dependent)
- `reg_index`  output  3  table entry currently being / last written

## Operation
- Table (index: sub-address <- data): 0: 0x12<-0x80 (COM7 soft reset), 1: 0x12<-0x00 (YUV), 2: 0x11<-0x01 (CLKRC), 3: 0x0C<-0x04 (COM3 DCW), 4: 0x3E<-0x1A (COM14), 5: 0x72<-0x22, 6: 0x73<-0xF2. NUM_REGS = 7.
- FSM: IDLE -> START -> BIT -> STOP -> GAP -> (WAIT_RST after entry 0) -> next entry START ... -> DONE.
- First cycle after `reset_n` rises: IDLE->START automatically; `busy`=1.
- DONE: `busy`=0, `done`=1; `start` re-enters START with `reg_index`=0, `done` cleared, `nack` cleared.
- `start` while `busy` ignored.
- Each write: 3 bytes MSB first, each followed by a 9th "don't-care" bit with `sio_d` released.

## Timing
- Reset values: `sio_c`=1, `sio_d`=z, `busy`=0, `done`=0, `nack`=0, `reg_index`=0; counters cleared. Reset mid-transaction aborts immediately to these values; the next run restarts from entry 0 with a fresh start condition.
- Quarter tick every CLK_DIV cycles; all pin changes occur on quarter ticks.
- START: 1 quarter with `sio_d`=0, `sio_c`=1, then 1 quarter with `sio_c`=0.
- BIT (per bit, quarters q0..q3): q0 `sio_c`=0, `sio_d` updated; q1 low; q2/q3 `sio_c`=1; data stable while `sio_c` high.
- STOP: q0 `sio_c`=0, `sio_d`=0; q1 `sio_c`=1; q2 `sio_d` released; q3 hold.
- GAP: 4 quarters, idle bus between transactions.
- One transaction = 2+27*4+4+4 = 118 quarters. WAIT_RST = RESET_WAIT cycles after entry 0's GAP.
- `reg_index` increments on GAP exit. `done` rises in the same cycle `busy` falls.

## Configuration
- `SCCB_ACK_CHECK_EN` defined: `sio_d` sampled at the q2 tick of each 9th bit; if it reads 1 (includes z), `nack` sets and stays set; the sequence continues regardless.
- Undefined: 9th bit not sampled; `nack` tied 0.

## Test plan
- Reset release, CLK_DIV=2, RESET_WAIT=20 -> first `sio_d` fall with `sio_c`=1 within 2 cycles of reset release; decoded bytes 0x42,0x12,0x80; `busy`=1.
- Full run with camera model acking low -> 7 transactions decode exactly as the table, 20-cycle idle after entry 0, then `done`=1, `busy`=0, `reg_index`=6, `nack`=0.
- Model never pulls ack low, macro defined -> `nack`=1 after the first ID byte, all 7 writes still emitted; macro undefined -> `nack`=0.
- `start` pulse mid-run -> ignored, no transaction restart; `start` after `done` -> `done`=0, new run from 0x12<-0x80, `nack` cleared.
- `reset_n` low during byte 2 of entry 3 -> same cycle `sio_c`=1, `sio_d`=z, `busy`=0; after release, run restarts at entry 0.
- Bus protocol check: `sio_d` never changes while `sio_c`=1 except at start/stop edges; each bit spans 4*CLK_DIV cycles.

Source files
------------

// File: rtl/sccb_config.sv
// sccb_config: walks the OV7670 register table, writing each entry as a 3-phase SCCB transaction.
// Optional feature macro: SCCB_ACK_CHECK_EN (sample the 9th bit and report a sticky nack).
module sccb_config #(
  parameter int unsigned CLK_DIV    = 63,
  parameter logic [7:0]  DEV_ID     = 8'h42,
  parameter int unsigned RESET_WAIT = 25000
) (
  input  logic       clk_25,
  input  logic       reset_n,
  input  logic       start,
  output logic       sio_c,
  inout  wire        sio_d,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic [2:0] reg_index
);

  localparam int unsigned NUM_REGS = 7;
  localparam int unsigned WW       = (RESET_WAIT > 1) ? $clog2(RESET_WAIT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BIT,
    S_STOP,
    S_GAP,
    S_WAIT_RST,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    div_q, div_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [3:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          sio_c_q, sio_c_d;
  logic          sda_low_q, sda_low_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [2:0]    idx_q, idx_d;
  logic          tick;
`ifdef SCCB_ACK_CHECK_EN
  logic          nack_q, nack_d;
`endif

  function automatic logic [15:0] table_entry(input logic [2:0] idx);
    logic [15:0] ent;
    case (idx)
      3'd0:    ent = 16'h1280;
      3'd1:    ent = 16'h1200;
      3'd2:    ent = 16'h1101;
      3'd3:    ent = 16'h0C04;
      3'd4:    ent = 16'h3E1A;
      3'd5:    ent = 16'h7222;
      3'd6:    ent = 16'h73F2;
      default: ent = '0;
    endcase
    return ent;
  endfunction

  // Bit 8 of every byte is the ack slot, where the line is released (value 1).
  function automatic logic tx_bit(input logic [2:0] idx, input logic [1:0] byte_sel,
                                  input logic [3:0] bit_sel);
    logic [15:0] ent;
    logic [7:0]  b;
    ent = table_entry(idx);
    case (byte_sel)
      2'd0:    b = DEV_ID;
      2'd1:    b = ent[15:8];
      default: b = ent[7:0];
    endcase
    if (bit_sel[3]) return 1'b1;
    return b[3'd7 - bit_sel[2:0]];
  endfunction

  assign tick = (div_q == 8'(CLK_DIV - 1));

  always_comb begin
    state_d   = state_q;
    div_d     = '0;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    wait_d    = wait_q;
    sio_c_d   = sio_c_q;
    sda_low_d = sda_low_q;
    busy_d    = busy_q;
    done_d    = done_q;
    idx_d     = idx_q;
`ifdef SCCB_ACK_CHECK_EN
    nack_d    = nack_q;
`endif

    if (state_q == S_START || state_q == S_BIT || state_q == S_STOP || state_q == S_GAP) begin
      div_d = tick ? '0 : div_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        state_d   = S_START;
        sio_c_d   = 1'b1;
        sda_low_d = 1'b1;
        busy_d    = 1'b1;
        qtr_d     = '0;
      end

      S_START: begin
        if (tick) begin
          if (qtr_q == 2'd0) begin
            qtr_d   = 2'd1;
            sio_c_d = 1'b0;
          end else begin
            state_d   = S_BIT;
            qtr_d     = '0;
            bit_d     = '0;
            byte_d    = '0;
            sda_low_d = ~tx_bit(idx_q, 2'd0, 4'd0);
          end
        end
      end

      S_BIT: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          case (qtr_q)
            2'd1: sio_c_d = 1'b1;
            2'd2: begin
`ifdef SCCB_ACK_CHECK_EN
              if (bit_q == 4'd8 && sio_d == 1'b1) nack_d = 1'b1;
`endif
            end
            2'd3: begin
              sio_c_d = 1'b0;
              if (bit_q == 4'd8) begin
                if (byte_q == 2'd2) begin
                  state_d   = S_STOP;
                  sda_low_d = 1'b1;
                end else begin
                  byte_d    = byte_q + 2'd1;
                  bit_d     = '0;
                  sda_low_d = ~tx_bit(idx_q, byte_q + 2'd1, 4'd0);
                end
              end else begin
                bit_d     = bit_q + 4'd1;
                sda_low_d = ~tx_bit(idx_q, byte_q, bit_q + 4'd1);
              end
            end
            default: ;
          endcase
        end
      end

      S_STOP: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          case (qtr_q)
            2'd0:    sio_c_d   = 1'b1;
            2'd1:    sda_low_d = 1'b0;
            2'd3:    state_d   = S_GAP;
            default: ;
          endcase
        end
      end

      S_GAP: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd3) begin
            if (idx_q == 3'(NUM_REGS - 1)) begin
              state_d = S_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + 3'd1;
              if (idx_q == 3'd0) begin
                state_d = S_WAIT_RST;
                wait_d  = '0;
              end else begin
                state_d   = S_START;
                sda_low_d = 1'b1;
              end
            end
          end
        end
      end

      S_WAIT_RST: begin
        if (wait_q == WW'(RESET_WAIT - 1)) begin
          state_d   = S_START;
          sda_low_d = 1'b1;
          qtr_d     = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      S_DONE: begin
        if (start) begin
          state_d   = S_START;
          idx_d     = '0;
          done_d    = 1'b0;
          busy_d    = 1'b1;
          sda_low_d = 1'b1;
          qtr_d     = '0;
`ifdef SCCB_ACK_CHECK_EN
          nack_d    = 1'b0;
`endif
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      qtr_q     <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      wait_q    <= '0;
      sio_c_q   <= 1'b1;
      sda_low_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      idx_q     <= '0;
`ifdef SCCB_ACK_CHECK_EN
      nack_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      wait_q    <= wait_d;
      sio_c_q   <= sio_c_d;
      sda_low_q <= sda_low_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      idx_q     <= idx_d;
`ifdef SCCB_ACK_CHECK_EN
      nack_q    <= nack_d;
`endif
    end
  end

  assign sio_c     = sio_c_q;
  assign sio_d     = sda_low_q ? 1'b0 : 1'bz;
  assign busy      = busy_q;
  assign done      = done_q;
  assign reg_index = idx_q;
`ifdef SCCB_ACK_CHECK_EN
  assign nack      = nack_q;
`else
  assign nack      = 1'b0;
`endif

endmodule

// File: tb/tb_sccb_config.sv
// Bench for sccb_config: per-cycle waveform timeline model, bus decoder/camera model, random start/abort.
module tb_sccb_config;
  localparam int unsigned CLK_DIV    = 2;
  localparam int unsigned RESET_WAIT = 20;
  localparam logic [7:0]  DEV_ID     = 8'h42;
`ifdef SCCB_ACK_CHECK_EN
  localparam bit ACK_CHK = 1'b1;
`else
  localparam bit ACK_CHK = 1'b0;
`endif
  localparam int LEN_TX = 118 * CLK_DIV;

  logic       clk_25  = 1'b0;
  logic       reset_n = 1'b0;
  logic       start   = 1'b0;
  logic       sio_c, busy, done, nack;
  logic [2:0] reg_index;
  wire        sio_d;
  logic       cam_drive = 1'b0;
  bit         cam_ack   = 1'b1;

  assign sio_d = (cam_drive && reset_n) ? 1'b0 : 1'bz;
  pullup (sio_d);

  sccb_config #(.CLK_DIV(CLK_DIV), .DEV_ID(DEV_ID), .RESET_WAIT(RESET_WAIT)) dut (
    .clk_25   (clk_25),
    .reset_n  (reset_n),
    .start    (start),
    .sio_c    (sio_c),
    .sio_d    (sio_d),
    .busy     (busy),
    .done     (done),
    .nack     (nack),
    .reg_index(reg_index)
  );

  always #5 clk_25 = ~clk_25;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] cfg(input int i);
    case (i)
      0:       return 16'h1280;
      1:       return 16'h1200;
      2:       return 16'h1101;
      3:       return 16'h0C04;
      4:       return 16'h3E1A;
      5:       return 16'h7222;
      default: return 16'h73F2;
    endcase
  endfunction

  // One expected sample per clock; nk: 0/1 expected nack, 2 = don't care.
  typedef struct packed {
    logic       c;
    logic       d;
    logic       busy;
    logic       done;
    logic [2:0] idx;
    logic [1:0] nk;
  } samp_t;

  samp_t       exp_q[$];
  int          n_pop = 0;
  logic [23:0] dec_q[$];

  task automatic push_q(input logic c, input logic d, input int idx, input int nk, input int n);
    samp_t s;
    s.c = c; s.d = d; s.busy = 1'b1; s.done = 1'b0; s.idx = 3'(idx); s.nk = 2'(nk);
    repeat (n) exp_q.push_back(s);
  endtask

  task automatic build_run(input bit ack);
    int          ns;
    logic [23:0] w;
    samp_t       s;
    ns = 0;
    exp_q.delete();
    dec_q.delete();
    n_pop = 0;
    for (int e = 0; e < 7; e++) begin
      w = {DEV_ID, cfg(e)};
      push_q(1, 0, e, ns, CLK_DIV);
      push_q(0, 0, e, ns, CLK_DIV);
      for (int by = 0; by < 3; by++) begin
        for (int b = 0; b < 8; b++) begin
          logic v;
          v = w[23 - 8 * by - b];
          push_q(0, v, e, ns, 2 * CLK_DIV);
          push_q(1, v, e, ns, 2 * CLK_DIV);
        end
        push_q(0, !ack, e, ns, 2 * CLK_DIV);
        push_q(1, !ack, e, (ACK_CHK && !ack && ns == 0) ? 2 : ns, CLK_DIV);
        if (ACK_CHK && !ack) ns = 1;
        push_q(1, !ack, e, ns, CLK_DIV);
      end
      push_q(0, 0, e, ns, CLK_DIV);
      push_q(1, 0, e, ns, CLK_DIV);
      push_q(1, 1, e, ns, 2 * CLK_DIV);
      push_q(1, 1, e, ns, 4 * CLK_DIV);
      if (e == 0) push_q(1, 1, 1, ns, RESET_WAIT);
    end
    s.c = 1'b1; s.d = 1'b1; s.busy = 1'b0; s.done = 1'b1; s.idx = 3'd6; s.nk = 2'(ns);
    repeat (5) exp_q.push_back(s);
  endtask

  always @(negedge clk_25) begin
    samp_t s;
    if (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      n_pop++;
      chk("sio_c", sio_c, s.c);
      chk("sio_d", sio_d, s.d);
      chk("busy", busy, s.busy);
      chk("done", done, s.done);
      chk("reg_index", reg_index, s.idx);
      if (s.nk != 2'd2) chk("nack", nack, s.nk);
    end
  end

  // Camera: decodes the bus, checks framing/bit period, optionally pulls the ack slot low.
  logic        pc = 1'b1, pd = 1'b1;
  bit          in_tx = 1'b0;
  int          nbits = 0, cyc = 0, last_rise = 0;
  logic [23:0] sh = '0;

  always begin
    @(posedge clk_25);
    #1;
    cyc++;
    if (!reset_n) begin
      in_tx     = 1'b0;
      cam_drive = 1'b0;
    end else begin
      if (pc && sio_c && pd && !sio_d) begin
        chk("start_mid_tx", in_tx, 0);
        in_tx = 1'b1;
        nbits = 0;
        sh    = '0;
      end else if (pc && sio_c && !pd && sio_d) begin
        if (in_tx) begin
          chk("stop_bits", nbits, 27);
          dec_q.push_back(sh);
        end
        in_tx = 1'b0;
      end else if (in_tx && !pc && sio_c && nbits < 27) begin
        if (nbits > 0) chk("bit_period", cyc - last_rise, 4 * CLK_DIV);
        last_rise = cyc;
        if (nbits % 9 != 8) sh = {sh[22:0], sio_d};
        nbits++;
      end else if (in_tx && pc && !sio_c) begin
        cam_drive = cam_ack && (nbits % 9 == 8) && (nbits < 27);
      end
    end
    pc = sio_c;
    pd = sio_d;
  end

  task automatic wait_run(input int stop_at);
    int guard;
    guard = 0;
    while (guard < 5000 && ((stop_at < 0) ? (exp_q.size() > 0) : (n_pop < stop_at))) begin
      @(negedge clk_25);
      #1;
      start = (exp_q.size() > 10) && ($urandom_range(0, 149) == 0);
      guard++;
    end
    start = 1'b0;
    chk("run_bound", int'(guard < 5000), 1);
  endtask

  task automatic end_checks(input bit ack);
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_reg_index", reg_index, 6);
    chk("end_nack", nack, (ACK_CHK && !ack) ? 1 : 0);
    chk("n_tx", dec_q.size(), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < dec_q.size()) chk("tx_decode", dec_q[i], {DEV_ID, cfg(i)});
    end
    chk("tx0_literal", (dec_q.size() > 0) ? int'(dec_q[0]) : 0, 24'h421280);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_sio_c"}, sio_c, 1);
    chk({tag, "_sio_d"}, sio_d, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_nack"}, nack, 0);
    chk({tag, "_reg_index"}, reg_index, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int target;

    repeat (3) @(negedge clk_25);
    check_reset_state("rst");

    // Run 1: camera acks, random ignored start pulses.
    cam_ack = 1'b1;
    #1;
    reset_n = 1'b1;
    build_run(1'b1);
    chk("model_len", exp_q.size(), 7 * 236 + 20 + 5);
    found = 1'b0;
    repeat (2) begin
      @(negedge clk_25);
      if (sio_c && !sio_d) found = 1'b1;
    end
    chk("first_fall", found, 1);
    chk("first_busy", busy, 1);
    wait_run(-1);
    end_checks(1'b1);

    // Run 2: restart from DONE, camera never acks.
    cam_ack = 1'b0;
    start   = 1'b1;
    build_run(1'b0);
    wait_run(-1);
    end_checks(1'b0);

    // Run 3: restart, abort with reset inside the third byte of entry 3.
    cam_ack = ($urandom_range(0, 1) == 1);
    start   = 1'b1;
    build_run(cam_ack);
    target = 3 * LEN_TX + RESET_WAIT + (74 + int'($urandom_range(0, 31))) * CLK_DIV
             + int'($urandom_range(0, CLK_DIV - 1));
    wait_run(target);
    chk("abort_point", n_pop, target);
    #1;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset_state("abort");
    repeat (3) @(negedge clk_25);
    #1;
    reset_n = 1'b1;
    build_run(cam_ack);
    wait_run(-1);
    end_checks(cam_ack);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
